// File: rtl/max7219_if_arbiter.sv
// ---------------------------------------------------------------------------
// max7219_if_arbiter
//
// Round-robin arbiter that lets up to four command sources share a single
// max7219_if serializer. The winning source's word and load enable are
// latched, one start pulse is issued, and after the serializer reports done a
// done pulse is returned to the owning source. A per-requester lock keeps
// ownership across multi-word frames so cascaded-device frames never
// interleave with another source's words.
//
// Parameters:
//   G_NB_REQ      number of requesters (1..4)
//   G_DATA_WIDTH  width of one MAX7219 word
//   G_TIMEOUT     BUSY watchdog limit in clk cycles (watchdog build only)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_en_load/i_lock   per-source request, load enable, keep-ownership
//   i_data                   flat bus, source k at [k*W+W-1:k*W]
//   o_ack / o_done           per-source 1-cycle accept / completion pulses
//   o_owner                  index of the last or current granted source
//   o_busy                   high whenever the FSM is not idle
//   o_max7219_if_start       1-cycle start pulse to the serializer
//   o_max7219_if_en_load     latched load enable for the serializer
//   o_max7219_if_data        latched word for the serializer
//   i_max7219_if_done        1-cycle done pulse from the serializer
//   o_timeout                1-cycle watchdog pulse (constant 0 by default)
//
// Build option: define MAX7219_ARB_TIMEOUT_EN to add the BUSY watchdog.
// ---------------------------------------------------------------------------
module max7219_if_arbiter #(
  parameter int G_NB_REQ     = 2,
  parameter int G_DATA_WIDTH = 16,
  parameter int G_TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [G_NB_REQ-1:0]              i_req,
  input  logic [G_NB_REQ-1:0]              i_en_load,
  input  logic [G_NB_REQ-1:0]              i_lock,
  input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data,
  output logic [G_NB_REQ-1:0]              o_ack,
  output logic [G_NB_REQ-1:0]              o_done,
  output logic [1:0]                       o_owner,
  output logic                             o_busy,
  output logic                             o_max7219_if_start,
  output logic                             o_max7219_if_en_load,
  output logic [G_DATA_WIDTH-1:0]          o_max7219_if_data,
  input  logic                             i_max7219_if_done,
  output logic                             o_timeout
);

  // Reject illegal configurations at elaboration time.
  if (G_NB_REQ < 1 || G_NB_REQ > 4 || G_TIMEOUT < 2) begin : g_bad_params
    $error("max7219_if_arbiter: G_NB_REQ must be 1..4 and G_TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [G_NB_REQ-1:0]     ack_q, ack_d;
  logic [G_NB_REQ-1:0]     done_q, done_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    en_load_q, en_load_d;
  logic [G_DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]              owner_q, owner_d;
  logic [1:0]              last_q, last_d;
  logic                    lock_q, lock_d;

  // Per-source views padded to four entries so the selects below always use
  // a plain 2-bit index regardless of G_NB_REQ.
  logic [3:0]              req4;
  logic [3:0]              en4;
  logic [3:0]              lock4;
  logic [3:0]              elig4;
  logic [G_DATA_WIDTH-1:0] data_arr [4];

  logic                    win_valid;
  logic [1:0]              win_idx;
  logic [2:0]              cand;
  logic [G_NB_REQ-1:0]     win_oh;
  logic [G_NB_REQ-1:0]     own_oh;

  assign req4  = 4'(i_req);
  assign en4   = 4'(i_en_load);
  assign lock4 = 4'(i_lock);

  for (genvar k = 0; k < 4; k++) begin : g_data
    if (k < G_NB_REQ) begin : g_used
      assign data_arr[k] = i_data[k*G_DATA_WIDTH +: G_DATA_WIDTH];
    end else begin : g_unused
      assign data_arr[k] = '0;
    end
  end

`ifdef MAX7219_ARB_TIMEOUT_EN
  localparam int CNT_W = (G_TIMEOUT > 2) ? $clog2(G_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Round-robin pick: scan upward from the source after the last winner,
  // wrapping modulo G_NB_REQ. While a frame is locked only the owner may win.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    elig4     = req4;
    if (lock_q) begin
      elig4 = req4 & (4'b0001 << owner_q);
    end
    for (int i = 1; i <= G_NB_REQ; i++) begin
      cand = {1'b0, last_q} + 3'(i);
      if (cand >= 3'(G_NB_REQ)) begin
        cand = cand - 3'(G_NB_REQ);
      end
      if (!win_valid && elig4[cand[1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  // One-hot vectors for the pending winner and the current owner.
  always_comb begin
    win_oh = '0;
    own_oh = '0;
    for (int k = 0; k < G_NB_REQ; k++) begin
      win_oh[k] = (win_idx == 2'(k));
      own_oh[k] = (owner_q == 2'(k));
    end
  end

  // Next-state and next-output logic. Pulses are computed on the transition
  // into a state so that, once registered, ack is high during START, start is
  // high in the first BUSY cycle and done is high during DONE.
  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    done_d    = '0;
    start_d   = 1'b0;
    en_load_d = en_load_q;
    data_d    = data_q;
    owner_d   = owner_q;
    last_d    = last_q;
    lock_d    = lock_q;
`ifdef MAX7219_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          data_d    = data_arr[win_idx];
          en_load_d = en4[win_idx];
          owner_d   = win_idx;
          last_d    = win_idx;
          ack_d     = win_oh;
          state_d   = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_BUSY;
`ifdef MAX7219_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_BUSY: begin
        // A done arriving on the expiry cycle wins over the watchdog.
        if (i_max7219_if_done) begin
          lock_d  = lock4[owner_q];
          done_d  = own_oh;
          state_d = S_DONE;
        end
`ifdef MAX7219_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(G_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          done_d    = own_oh;
          lock_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs. Reset aborts any transfer without a done
  // pulse and gives source 0 first priority on the next arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ack_q     <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      en_load_q <= 1'b0;
      data_q    <= '0;
      owner_q   <= '0;
      last_q    <= 2'(G_NB_REQ - 1);
      lock_q    <= 1'b0;
`ifdef MAX7219_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      en_load_q <= en_load_d;
      data_q    <= data_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
`ifdef MAX7219_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_ack                = ack_q;
  assign o_done               = done_q;
  assign o_owner              = owner_q;
  assign o_busy               = busy_q;
  assign o_max7219_if_start   = start_q;
  assign o_max7219_if_en_load = en_load_q;
  assign o_max7219_if_data    = data_q;

endmodule

// File: tb/tb_max7219_if_arbiter.sv
// ---------------------------------------------------------------------------
// tb_max7219_if_arbiter
//
// Self-checking bench for max7219_if_arbiter with two requesters. A small
// serializer model answers each start pulse with a done pulse after a
// programmable delay. Expected grants are queued when requests are driven and
// popped when the arbiter issues the corresponding start pulse.
// ---------------------------------------------------------------------------
module tb_max7219_if_arbiter;

  localparam int NB  = 2;
  localparam int W   = 16;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] req;
  logic [NB-1:0] en;
  logic [NB-1:0] lock;
  logic [NB*W-1:0] data;
  logic [NB-1:0] ack;
  logic [NB-1:0] done;
  logic [1:0]    owner;
  logic          busy;
  logic          start;
  logic          if_en_load;
  logic [W-1:0]  if_data;
  logic          if_done;
  logic          timeout;

  logic          ser_done;
  logic          spur_done;
  bit            ser_auto;
  int            ser_dly;
  int            ser_cnt;

  typedef struct {
    int         src;
    logic [W-1:0] data;
    logic       en;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;

  assign if_done = ser_done | spur_done;

  max7219_if_arbiter #(
    .G_NB_REQ     (NB),
    .G_DATA_WIDTH (W),
    .G_TIMEOUT    (TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_req                (req),
    .i_en_load            (en),
    .i_lock               (lock),
    .i_data               (data),
    .o_ack                (ack),
    .o_done               (done),
    .o_owner              (owner),
    .o_busy               (busy),
    .o_max7219_if_start   (start),
    .o_max7219_if_en_load (if_en_load),
    .o_max7219_if_data    (if_data),
    .i_max7219_if_done    (if_done),
    .o_timeout            (timeout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Serializer model: ser_dly cycles after a start pulse it raises done for
  // one cycle. Disabled while ser_auto is low, cleared by reset.
  initial begin
    ser_done = 1'b0;
    ser_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      ser_done = 1'b0;
      if (rst) begin
        ser_cnt = 0;
      end else if (ser_cnt > 0) begin
        ser_cnt = ser_cnt - 1;
        if (ser_cnt == 0) ser_done = 1'b1;
      end else if (ser_auto && start) begin
        ser_cnt = ser_dly;
      end
    end
  end

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values of every output.
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (ack !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ack: got %b expected 00", ack); end
    n_cmp++; if (done !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 00", done); end
    n_cmp++; if (start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_start: got %b expected 0", start); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (owner !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner); end
    n_cmp++; if (if_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0000", if_data); end
    n_cmp++; if (if_en_load !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_en_load: got %b expected 0", if_en_load); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  // Minimum handshake of one word from source 0.
  task automatic test_single();
    exp_t e;
    int   c;
    data[15:0] = 16'h0C01;
    en         = 2'b01;
    req        = 2'b01;
    sb.push_back('{src: 0, data: 16'h0C01, en: 1'b1});
    tick();
    n_cmp++; if (ack !== 2'b01) begin n_fail++; $display("[TB] FAIL single_ack: got %b expected 01", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    n_cmp++; if (start !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_start: got %b expected 0", start); end
    req = 2'b00;
    tick();
    n_cmp++; if (start !== 1'b1) begin n_fail++; $display("[TB] FAIL single_start: got %b expected 1", start); end
    n_cmp++; if (ack !== 2'b00) begin n_fail++; $display("[TB] FAIL single_ack_width: got %b expected 00", ack); end
    e = sb.pop_front();
    n_cmp++; if (if_data !== e.data) begin n_fail++; $display("[TB] FAIL single_data: got %h expected %h", if_data, e.data); end
    n_cmp++; if (if_en_load !== e.en) begin n_fail++; $display("[TB] FAIL single_en_load: got %b expected %b", if_en_load, e.en); end
    n_cmp++; if (owner !== 2'(e.src)) begin n_fail++; $display("[TB] FAIL single_owner: got %0d expected %0d", owner, e.src); end
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done !== 2'b00) begin
        c = i;
        break;
      end
    end
    n_cmp++; if (c != ser_dly + 1) begin n_fail++; $display("[TB] FAIL single_done_latency: got %0d cycles expected %0d", c, ser_dly + 1); end
    n_cmp++; if (done !== 2'b01) begin n_fail++; $display("[TB] FAIL single_done: got %b expected 01", done); end
    n_cmp++; if (if_data !== 16'h0C01) begin n_fail++; $display("[TB] FAIL single_data_hold: got %h expected 0c01", if_data); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_back_idle: got %b expected 0", busy); end
  endtask

  // Both sources requesting from reset: strict alternation starting at 0.
  task automatic test_round_robin();
    exp_t       e;
    logic [1:0] exp_ack;
    int         acks;
    int         dones;
    int         cur;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data  = {16'h0B07, 16'h0A05};
    en    = 2'b01;
    acks  = 0;
    dones = 0;
    cur   = 0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) sb.push_back('{src: 0, data: 16'h0A05, en: 1'b1});
      else            sb.push_back('{src: 1, data: 16'h0B07, en: 1'b0});
    end
    req = 2'b11;
    for (int c = 0; c < 200 && dones < 4; c++) begin
      tick();
      if (ack !== 2'b00) begin
        exp_ack = (sb.size() > 0) ? 2'(1 << sb[0].src) : 2'b00;
        n_cmp++; if (ack !== exp_ack) begin n_fail++; $display("[TB] FAIL rr_ack: got %b expected %b", ack, exp_ack); end
        acks++;
        if (acks == 4) req = 2'b00;
      end
      if (start === 1'b1) begin
        e = sb.pop_front();
        cur = e.src;
        n_cmp++; if (if_data !== e.data) begin n_fail++; $display("[TB] FAIL rr_data: got %h expected %h", if_data, e.data); end
        n_cmp++; if (if_en_load !== e.en) begin n_fail++; $display("[TB] FAIL rr_en_load: got %b expected %b", if_en_load, e.en); end
        n_cmp++; if (owner !== 2'(e.src)) begin n_fail++; $display("[TB] FAIL rr_owner: got %0d expected %0d", owner, e.src); end
      end
      if (done !== 2'b00) begin
        n_cmp++; if (done !== 2'(1 << cur)) begin n_fail++; $display("[TB] FAIL rr_done: got %b expected %b", done, 2'(1 << cur)); end
        dones++;
      end
    end
    n_cmp++; if (dones != 4) begin n_fail++; $display("[TB] FAIL rr_completed: got %0d words expected 4", dones); end
    req = 2'b00;
    tick();
  endtask

  // Source 0 sends a three-word locked frame while source 1 keeps requesting.
  task automatic test_lock();
    exp_t       e;
    logic [1:0] exp_ack;
    int         acks;
    int         dones;
    int         done0;
    int         cur;
    sb.delete();
    data  = {16'h0944, 16'h0101};
    en    = 2'b11;
    lock  = 2'b01;
    acks  = 0;
    dones = 0;
    done0 = 0;
    cur   = 0;
    sb.push_back('{src: 0, data: 16'h0101, en: 1'b1});
    sb.push_back('{src: 0, data: 16'h0202, en: 1'b1});
    sb.push_back('{src: 0, data: 16'h0303, en: 1'b1});
    sb.push_back('{src: 1, data: 16'h0944, en: 1'b1});
    req = 2'b11;
    for (int c = 0; c < 300 && dones < 4; c++) begin
      tick();
      if (ack !== 2'b00) begin
        exp_ack = (sb.size() > 0) ? 2'(1 << sb[0].src) : 2'b00;
        n_cmp++; if (ack !== exp_ack) begin n_fail++; $display("[TB] FAIL lock_ack: got %b expected %b", ack, exp_ack); end
        n_cmp++; if (ack[1] === 1'b1 && done0 < 3) begin n_fail++; $display("[TB] FAIL lock_interleave: ack1 after %0d done0 expected 3", done0); end
        acks++;
        case (acks)
          1: data[15:0] = 16'h0202;
          2: data[15:0] = 16'h0303;
          3: begin lock = 2'b00; req[0] = 1'b0; end
          default: req = 2'b00;
        endcase
      end
      if (start === 1'b1) begin
        e = sb.pop_front();
        cur = e.src;
        n_cmp++; if (if_data !== e.data) begin n_fail++; $display("[TB] FAIL lock_data: got %h expected %h", if_data, e.data); end
        n_cmp++; if (owner !== 2'(e.src)) begin n_fail++; $display("[TB] FAIL lock_owner: got %0d expected %0d", owner, e.src); end
      end
      if (done !== 2'b00) begin
        n_cmp++; if (done !== 2'(1 << cur)) begin n_fail++; $display("[TB] FAIL lock_done: got %b expected %b", done, 2'(1 << cur)); end
        if (done[0] === 1'b1) done0++;
        dones++;
      end
    end
    n_cmp++; if (dones != 4) begin n_fail++; $display("[TB] FAIL lock_completed: got %0d words expected 4", dones); end
    req = 2'b00;
    tick();
  endtask

  // A done pulse from the serializer while idle must be ignored.
  task automatic test_spurious_done();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (done !== 2'b00) begin n_fail++; $display("[TB] FAIL spur_done: got %b expected 00", done); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_busy: got %b expected 0", busy); end
      n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL spur_timeout: got %b expected 0", timeout); end
    end
  endtask

  // Reset while waiting on the serializer, then check priority restarts at 0.
  task automatic test_reset_mid_busy();
    exp_t e;
    bit   seen;
    sb.delete();
    ser_auto   = 1'b0;
    data[15:0] = 16'h0F0F;
    en         = 2'b01;
    req        = 2'b01;
    sb.push_back('{src: 0, data: 16'h0F0F, en: 1'b1});
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ack !== 2'b00) req = 2'b00;
      if (start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("[TB] FAIL rst_busy_start: got none expected start"); end
    e = sb.pop_front();
    n_cmp++; if (if_data !== e.data) begin n_fail++; $display("[TB] FAIL rst_busy_data: got %h expected %h", if_data, e.data); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy_busy: got %b expected 0", busy); end
    n_cmp++; if (if_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_busy_data_clr: got %h expected 0000", if_data); end
    n_cmp++; if (if_en_load !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy_en_clr: got %b expected 0", if_en_load); end
    n_cmp++; if (owner !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_busy_owner: got %0d expected 0", owner); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (done !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_busy_no_done: got %b expected 00", done); end
      tick();
    end
    ser_auto = 1'b1;
    data     = {16'h0BBB, 16'h0123};
    sb.push_back('{src: 0, data: 16'h0123, en: 1'b1});
    req = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ack !== 2'b00) begin
        n_cmp++; if (ack !== 2'b01) begin n_fail++; $display("[TB] FAIL rst_busy_first_grant: got %b expected 01", ack); end
        req = 2'b00;
      end
      if (start === 1'b1) begin
        e = sb.pop_front();
        n_cmp++; if (if_data !== e.data) begin n_fail++; $display("[TB] FAIL rst_busy_regrant_data: got %h expected %h", if_data, e.data); end
      end
      if (done !== 2'b00) begin
        seen = 1'b1;
        n_cmp++; if (done !== 2'b01) begin n_fail++; $display("[TB] FAIL rst_busy_regrant_done: got %b expected 01", done); end
        break;
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("[TB] FAIL rst_busy_regrant: got no done expected done"); end
    req = 2'b00;
    tick();
  endtask

`ifdef MAX7219_ARB_TIMEOUT_EN
  // Serializer never answers: watchdog must fire TMO cycles into BUSY.
  task automatic test_timeout();
    int c;
    bit seen;
    ser_auto   = 1'b0;
    data[15:0] = 16'h0777;
    req        = 2'b01;
    seen       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack !== 2'b00) req = 2'b00;
      if (start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("[TB] FAIL tmo_start: got none expected start"); end
    c = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (timeout === 1'b1) begin
        c = i;
        break;
      end
    end
    n_cmp++; if (c != TMO) begin n_fail++; $display("[TB] FAIL tmo_latency: got %0d cycles expected %0d", c, TMO); end
    n_cmp++; if (done !== 2'b01) begin n_fail++; $display("[TB] FAIL tmo_done: got %b expected 01", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_idle: got %b expected 0", busy); end
    tick();
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_pulse: got %b expected 0", timeout); end
    ser_auto = 1'b1;
  endtask
`endif

  // Test sequence and summary.
  initial begin
    rst       = 1'b1;
    req       = '0;
    en        = '0;
    lock      = '0;
    data      = '0;
    spur_done = 1'b0;
    ser_auto  = 1'b1;
    ser_dly   = 3;
    n_cmp     = 0;
    n_fail    = 0;
    $display("[TB] start");
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_spurious_done();
    test_reset_mid_busy();
`ifdef MAX7219_ARB_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_empty: got %0d left expected 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
